// File: rtl/rv32i_types.sv
// Shared types for the load/store unit.
//   lsu_state_t : unit FSM states
//   lsu_size_t  : funct3[1:0] access-size encoding
//   F3_UNSIGNED : funct3 bit selecting zero-extension on loads
//   f3_illegal  : funct3/direction legality for a given data width
//   size_bytes  : access size in bytes
package rv32i_types;

    typedef enum logic [1:0] {IDLE, ACCESS1, ACCESS2, DONE} lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } lsu_size_t;

    localparam int F3_UNSIGNED = 2;

    function automatic logic f3_illegal(input logic [2:0] f3, input logic we, input int data_w);
        if (f3 == 3'b111) return 1'b1;
        if (we && f3[F3_UNSIGNED]) return 1'b1;
        // A 32-bit datapath has no doubleword and no lwu.
        if (data_w == 32 && (f3[1:0] == SZ_DOUBLE || f3 == 3'b110)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for loads and stores (combinational).
//   size, is_unsigned, offset : access size, zero-extend flag, byte offset in word
//   wdata                     : LSB-justified store data
//   wdata_lo/hi, be_lo/hi     : store data and byte enables for beat 1 / beat 2
//   rdata_lo/hi               : read data of beat 1 / beat 2
//   rdata_ext                 : shifted, masked and extended load result
// Both directions work on a double-width window {beat2, beat1}, so a split
// access and a single-beat access share the same shifting logic.
module lsu_align import rv32i_types::*; #(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                   size,
    input  logic                         is_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]  offset,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            wdata_lo,
    output logic [DATA_W-1:0]            wdata_hi,
    output logic [DATA_W/8-1:0]          be_lo,
    output logic [DATA_W/8-1:0]          be_hi,
    input  logic [DATA_W-1:0]            rdata_lo,
    input  logic [DATA_W-1:0]            rdata_hi,
    output logic [DATA_W-1:0]            rdata_ext
);
    localparam int BYTES = DATA_W / 8;

    int                  nbytes;
    logic [2*BYTES-1:0]  be_wide;
    logic [DATA_W-1:0]   ld_raw;
    logic [DATA_W-1:0]   bit_mask;
    logic                sign;

    assign nbytes = size_bytes(size);

    assign {wdata_hi, wdata_lo} = {{DATA_W{1'b0}}, wdata} << {offset, 3'b000};

    for (genvar i = 0; i < 2*BYTES; i++) begin : g_lane
        assign be_wide[i] = (i >= int'(offset)) && (i < int'(offset) + nbytes);
    end
    assign {be_hi, be_lo} = be_wide;

    assign ld_raw = DATA_W'({rdata_hi, rdata_lo} >> {offset, 3'b000});

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign bit_mask[i] = (i < 8*nbytes);
    end

    always_comb begin
        sign = 1'b0;
        case (size)
            SZ_BYTE: sign = ld_raw[7];
            SZ_HALF: sign = ld_raw[15];
            SZ_WORD: sign = ld_raw[31];
            default: sign = ld_raw[DATA_W-1];
        endcase
    end

    assign rdata_ext = (ld_raw & bit_mask) | ({DATA_W{sign & ~is_unsigned}} & ~bit_mask);

endmodule

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: one request at a time, one or two memory beats.
//   req_*   : request handshake (req_ready high only when idle)
//   mem_*   : memory strobes, aligned address, lane data/enables, response
//   rsp_*   : one-cycle completion pulse with load data and fault flags
// Word-crossing accesses either split into two beats or fault, depending on
// SPLIT_MISALIGNED. Faulting/illegal requests never touch memory.
module load_store_unit import rv32i_types::*; #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic [DATA_W/8-1:0]  mem_byte_enable,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_resp,
    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_misaligned,
    output logic                 rsp_illegal
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFFW  = $clog2(BYTES);

    lsu_state_t state, state_d;

    logic               r_we, r_cross, r_mis, r_ill, gap;
    logic [2:0]         r_funct3;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata, beat_lo, beat_hi;

    logic [OFFW-1:0]    req_off;
    logic               req_cross, req_ill, req_fault, accept;
    logic               in_access, strobe, beat_done;
    logic [ADDR_W-1:0]  base, next_base;
    logic [DATA_W-1:0]  st_lo, st_hi, ld_data;
    logic [BYTES-1:0]   be_lo, be_hi;

    // Request decode, evaluated on the raw inputs at acceptance.
    assign req_off   = req_addr[OFFW-1:0];
    assign req_cross = (int'(req_off) + size_bytes(req_funct3[1:0])) > BYTES;
    assign req_ill   = f3_illegal(req_funct3, req_we, DATA_W);
    assign req_fault = req_ill || (req_cross && !SPLIT_MISALIGNED);
    assign accept    = req_valid && (state == IDLE);

    // gap forces the strobes low for the cycle after every beat completes,
    // including the turnaround between ACCESS1 and ACCESS2.
    assign in_access = (state == ACCESS1) || (state == ACCESS2);
    assign strobe    = in_access && !gap;
    assign beat_done = strobe && mem_resp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (req_valid) state_d = req_fault ? DONE : ACCESS1;
            ACCESS1: if (beat_done) state_d = r_cross ? ACCESS2 : DONE;
            ACCESS2: if (beat_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cross  <= 1'b0;
            r_mis    <= 1'b0;
            r_ill    <= 1'b0;
            gap      <= 1'b0;
            beat_lo  <= '0;
            beat_hi  <= '0;
        end else begin
            gap <= beat_done;
            if (accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_cross  <= req_cross;
                r_ill    <= req_ill;
                r_mis    <= !req_ill && req_cross && !SPLIT_MISALIGNED;
                beat_lo  <= '0;
                beat_hi  <= '0;
            end
            if (beat_done && state == ACCESS1) beat_lo <= mem_rdata;
            if (beat_done && state == ACCESS2) beat_hi <= mem_rdata;
        end
    end

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .size        (r_funct3[1:0]),
        .is_unsigned (r_funct3[F3_UNSIGNED]),
        .offset      (r_addr[OFFW-1:0]),
        .wdata       (r_wdata),
        .wdata_lo    (st_lo),
        .wdata_hi    (st_hi),
        .be_lo       (be_lo),
        .be_hi       (be_hi),
        .rdata_lo    (beat_lo),
        .rdata_hi    (beat_hi),
        .rdata_ext   (ld_data)
    );

    assign base      = {r_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign next_base = base + ADDR_W'(BYTES);

    assign req_ready       = (state == IDLE);
    assign mem_read        = strobe && !r_we;
    assign mem_write       = strobe && r_we;
    assign mem_address     = strobe ? ((state == ACCESS2) ? next_base : base) : '0;
    assign mem_byte_enable = strobe ? ((state == ACCESS2) ? be_hi : be_lo) : '0;
    assign mem_wdata       = (strobe && r_we) ? ((state == ACCESS2) ? st_hi : st_lo) : '0;

    assign rsp_valid      = (state == DONE);
    assign rsp_misaligned = rsp_valid && r_mis;
    assign rsp_illegal    = rsp_valid && r_ill;
    assign rsp_rdata      = (rsp_valid && !r_we && !r_mis && !r_ill) ? ld_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 32-bit split unit (a) and 32-bit faulting unit (b) share request fields.
    logic        req_valid_a, req_valid_b, req_we, mem_resp_a, mem_resp_b;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        req_ready_a, mem_read_a, mem_write_a, rsp_valid_a, rsp_mis_a, rsp_ill_a;
    logic [31:0] mem_address_a, mem_wdata_a, rsp_rdata_a;
    logic [3:0]  mem_be_a;
    logic        req_ready_b, mem_read_b, mem_write_b, rsp_valid_b, rsp_mis_b, rsp_ill_b;
    logic [31:0] mem_address_b, mem_wdata_b, rsp_rdata_b;
    logic [3:0]  mem_be_b;

    // 64-bit unit (c).
    logic        req_valid_c, req_we_c, mem_resp_c;
    logic [2:0]  req_funct3_c;
    logic [31:0] req_addr_c;
    logic [63:0] req_wdata_c, mem_rdata_c;
    logic        req_ready_c, mem_read_c, mem_write_c, rsp_valid_c, rsp_mis_c, rsp_ill_c;
    logic [31:0] mem_address_c;
    logic [63:0] mem_wdata_c, rsp_rdata_c;
    logic [7:0]  mem_be_c;

    load_store_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_address(mem_address_a),
        .mem_wdata(mem_wdata_a), .mem_byte_enable(mem_be_a), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp_a), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
        .rsp_misaligned(rsp_mis_a), .rsp_illegal(rsp_ill_a));

    load_store_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_address(mem_address_b),
        .mem_wdata(mem_wdata_b), .mem_byte_enable(mem_be_b), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
        .rsp_misaligned(rsp_mis_b), .rsp_illegal(rsp_ill_b));

    load_store_unit #(.DATA_W(64), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) u_c (
        .clk(clk), .rst(rst), .req_valid(req_valid_c), .req_ready(req_ready_c),
        .req_we(req_we_c), .req_funct3(req_funct3_c), .req_addr(req_addr_c), .req_wdata(req_wdata_c),
        .mem_read(mem_read_c), .mem_write(mem_write_c), .mem_address(mem_address_c),
        .mem_wdata(mem_wdata_c), .mem_byte_enable(mem_be_c), .mem_rdata(mem_rdata_c),
        .mem_resp(mem_resp_c), .rsp_valid(rsp_valid_c), .rsp_rdata(rsp_rdata_c),
        .rsp_misaligned(rsp_mis_c), .rsp_illegal(rsp_ill_c));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request on unit a. d0/d1: read data to return (loads) or expected
    // lane data (stores) for beat 1 / beat 2.
    task automatic txn_a(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int nbeats,
                         input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] d1,
                         input logic [31:0] erd, input logic emis, input logic eill);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            int n;
            n = 0;
            while (!(mem_read_a || mem_write_a) && n < 8) begin
                @(posedge clk); #1;
                n++;
            end
            chk({tag, ".rd"}, mem_read_a, !we);
            chk({tag, ".wr"}, mem_write_a, we);
            chk({tag, ".addr"}, mem_address_a, (b == 0) ? a0 : a1);
            chk({tag, ".be"}, mem_be_a, (b == 0) ? be0 : be1);
            if (we) chk({tag, ".wdata"}, mem_wdata_a, (b == 0) ? d0 : d1);
            else    mem_rdata = (b == 0) ? d0 : d1;
            mem_resp_a = 1'b1;
            @(posedge clk); #1;
            mem_resp_a = 1'b0;
            mem_rdata  = '0;
            chk({tag, ".gap"}, {mem_read_a, mem_write_a}, 2'b00);
        end
        if (nbeats == 0) chk({tag, ".nomem"}, {mem_read_a, mem_write_a}, 2'b00);
        chk({tag, ".vld"}, rsp_valid_a, 1'b1);
        chk({tag, ".rdata"}, rsp_rdata_a, erd);
        chk({tag, ".mis"}, rsp_mis_a, emis);
        chk({tag, ".ill"}, rsp_ill_a, eill);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, rsp_valid_a, 1'b0);
        chk({tag, ".ready"}, req_ready_a, 1'b1);
    endtask

    task automatic load_c(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] eaddr, input logic [7:0] ebe,
                          input logic [63:0] rd, input logic [63:0] erd);
        int n;
        req_we_c = 1'b0; req_funct3_c = f3; req_addr_c = addr;
        req_valid_c = 1'b1;
        @(posedge clk); #1;
        req_valid_c = 1'b0;
        n = 0;
        while (!mem_read_c && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".rd"}, mem_read_c, 1'b1);
        chk({tag, ".addr"}, mem_address_c, eaddr);
        chk({tag, ".be"}, mem_be_c, ebe);
        mem_rdata_c = rd; mem_resp_c = 1'b1;
        @(posedge clk); #1;
        mem_resp_c = 1'b0; mem_rdata_c = '0;
        chk({tag, ".vld"}, rsp_valid_c, 1'b1);
        chk({tag, ".rdata"}, rsp_rdata_c, erd);
        @(posedge clk); #1;
    endtask

    initial begin
        req_valid_a = 0; req_valid_b = 0; req_we = 0; req_funct3 = 0; req_addr = 0;
        req_wdata = 0; mem_rdata = 0; mem_resp_a = 0; mem_resp_b = 0;
        req_valid_c = 0; req_we_c = 0; req_funct3_c = 0; req_addr_c = 0;
        req_wdata_c = 0; mem_rdata_c = 0; mem_resp_c = 0;

        #2;
        chk("rst.ready", req_ready_a, 1'b1);
        chk("rst.strobes", {mem_read_a, mem_write_a}, 2'b00);
        chk("rst.addr", mem_address_a, 32'h0);
        chk("rst.be", mem_be_a, 4'h0);
        chk("rst.rsp", {rsp_valid_a, rsp_mis_a, rsp_ill_a}, 3'b000);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Response pulse while idle is ignored.
        mem_resp_a = 1'b1;
        @(posedge clk); #1;
        mem_resp_a = 1'b0;
        chk("idle_resp.vld", rsp_valid_a, 1'b0);
        chk("idle_resp.ready", req_ready_a, 1'b1);

        //     tag         we  f3      addr          wdata         nb  a0            be0      d0             a1         be1      d1             erd            mis ill
        txn_a("lb",        0, 3'b000, 32'h00000103, 32'h0,        1, 32'h00000100, 4'b1000, 32'h80000000, 32'h0,     4'b0000, 32'h0,        32'hFFFFFF80, 0, 0);
        txn_a("lbu",       0, 3'b100, 32'h00000103, 32'h0,        1, 32'h00000100, 4'b1000, 32'h80000000, 32'h0,     4'b0000, 32'h0,        32'h00000080, 0, 0);
        txn_a("sh",        1, 3'b001, 32'h00000102, 32'h0000BEEF, 1, 32'h00000100, 4'b1100, 32'hBEEF0000, 32'h0,     4'b0000, 32'h0,        32'h0,        0, 0);
        txn_a("lw_split",  0, 3'b010, 32'h000000FE, 32'h0,        2, 32'h000000FC, 4'b1100, 32'h11223344, 32'h100,   4'b0011, 32'h55667788, 32'h77881122, 0, 0);
        txn_a("lh_inword", 0, 3'b001, 32'h00000101, 32'h0,        1, 32'h00000100, 4'b0110, 32'h00ABCD00, 32'h0,     4'b0000, 32'h0,        32'hFFFFABCD, 0, 0);
        txn_a("sw_split",  1, 3'b010, 32'h00000103, 32'hAABBCCDD, 2, 32'h00000100, 4'b1000, 32'hDD000000, 32'h104,   4'b0111, 32'h00AABBCC, 32'h0,        0, 0);
        txn_a("lh_wrap",   0, 3'b001, 32'hFFFFFFFF, 32'h0,        2, 32'hFFFFFFFC, 4'b1000, 32'h12000000, 32'h0,     4'b0001, 32'h00000034, 32'h00003412, 0, 0);
        txn_a("lw",        0, 3'b010, 32'h00000200, 32'h0,        1, 32'h00000200, 4'b1111, 32'hCAFEF00D, 32'h0,     4'b0000, 32'h0,        32'hCAFEF00D, 0, 0);
        txn_a("ld_ill",    0, 3'b011, 32'h00000100, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,     4'b0000, 32'h0,        32'h0,        0, 1);
        txn_a("lwu_ill",   0, 3'b110, 32'h00000100, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,     4'b0000, 32'h0,        32'h0,        0, 1);
        txn_a("sbu_ill",   1, 3'b100, 32'h00000100, 32'h12,       0, 32'h0,        4'b0000, 32'h0,        32'h0,     4'b0000, 32'h0,        32'h0,        0, 1);
        txn_a("f3_7_ill",  0, 3'b111, 32'h00000100, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,     4'b0000, 32'h0,        32'h0,        0, 1);

        // Word-crossing load on the non-splitting unit faults one cycle after acceptance.
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h000000FE;
        req_valid_b = 1'b1;
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        chk("mis.vld", rsp_valid_b, 1'b1);
        chk("mis.flag", rsp_mis_b, 1'b1);
        chk("mis.ill", rsp_ill_b, 1'b0);
        chk("mis.nomem", {mem_read_b, mem_write_b}, 2'b00);
        chk("mis.rdata", rsp_rdata_b, 32'h0);
        @(posedge clk); #1;
        chk("mis.pulse", rsp_valid_b, 1'b0);

        // Reset in the middle of a load abandons it; a late response is ignored.
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h00000100;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        chk("rstmid.busy", mem_read_a, 1'b1);
        rst = 1'b0;
        #1;
        chk("rstmid.rd", mem_read_a, 1'b0);
        chk("rstmid.ready", req_ready_a, 1'b1);
        #2 rst = 1'b1;
        mem_rdata = 32'hDEADBEEF; mem_resp_a = 1'b1;
        @(posedge clk); #1;
        mem_resp_a = 1'b0; mem_rdata = '0;
        chk("rstmid.vld0", rsp_valid_a, 1'b0);
        @(posedge clk); #1;
        chk("rstmid.vld1", rsp_valid_a, 1'b0);
        chk("rstmid.rd1", mem_read_a, 1'b0);
        chk("rstmid.ready1", req_ready_a, 1'b1);

        // 64-bit datapath.
        load_c("lwu64", 3'b110, 32'h00000104, 32'h00000100, 8'hF0,
               64'h80000001_00000000, 64'h00000000_80000001);
        load_c("lw64",  3'b010, 32'h00000104, 32'h00000100, 8'hF0,
               64'h80000001_00000000, 64'hFFFFFFFF_80000001);
        load_c("lb64",  3'b000, 32'h00000107, 32'h00000100, 8'h80,
               64'h80000000_00000000, 64'hFFFFFFFF_FFFFFF80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory/register data width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter SPLIT_MISALIGNED, default 0. At 1, word-crossing accesses split into two beats; at 0, they fault.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  access request.
REQ-007 req_ready  out  1  unit idle and accepting.
REQ-008 req_we  in  1  1=store, 0=load.
REQ-009 req_funct3  in  3  RISC-V load/store funct3.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  store data, LSB-justified.
REQ-012 mem_read / mem_write  out  1 each  memory strobes.
REQ-013 mem_address  out  ADDR_W  address aligned to DATA_W/8.
REQ-014 mem_wdata  out  DATA_W  lane-shifted store data.
REQ-015 mem_byte_enable  out  DATA_W/8  active byte lanes.
REQ-016 mem_rdata  in  DATA_W  read data, valid with mem_resp.
REQ-017 mem_resp  in  1  memory beat complete.
REQ-018 rsp_valid  out  1  one-cycle completion pulse.
REQ-019 rsp_rdata  out  DATA_W  extended load result.
REQ-020 rsp_misaligned / rsp_illegal  out  1 each  fault flags, valid with rsp_valid.

Function
REQ-021 SHALL use FSM states IDLE, ACCESS1, ACCESS2, DONE; req_ready=1 only in IDLE.
REQ-022 On req_valid&&req_ready, SHALL register the request and go to ACCESS1, or to DONE on a fault.
REQ-023 Sizes: funct3[1:0] 00=byte, 01=half, 10=word, 11=double; funct3[2]=1 means zero-extend (loads only).
REQ-024 Illegal: double or word-unsigned when DATA_W=32; funct3 111; store with funct3[2]=1. SHALL set rsp_illegal and perform no memory access.
REQ-025 Misaligned means addr mod size != 0. If the access stays within one DATA_W word, SHALL complete in a single beat with no fault.
REQ-026 Word-crossing with SPLIT_MISALIGNED=0: SHALL set rsp_misaligned and perform no memory access. rsp_valid SHALL rise one cycle after acceptance.
REQ-027 Word-crossing with SPLIT_MISALIGNED=1:
- ACCESS1 SHALL target the aligned base address.
- ACCESS2 SHALL target base+DATA_W/8.
- Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-028 In ACCESS states, mem_read/mem_write SHALL hold steady until mem_resp, then deassert for at least one cycle.
REQ-029 Store: mem_wdata = wdata << 8*offset; byte_enable = size-mask << offset. For a split store, beat 2 SHALL carry the overflow bytes in its low lanes.
REQ-030 Load: SHALL shift right by 8*offset, mask to size, and sign- or zero-extend to DATA_W. For a split load, SHALL concatenate beat-2 low bytes above the beat-1 high bytes.
REQ-031 DONE SHALL last one cycle with rsp_valid=1, then return to IDLE. There is no response backpressure.
REQ-032 rsp_rdata SHALL be 0 for stores and faults.
REQ-033 mem_resp outside ACCESS states SHALL be ignored.

Reset
REQ-034 rst low SHALL immediately force state IDLE. All outputs SHALL be 0 except req_ready=1.
REQ-035 Reset during ACCESS1/ACCESS2 SHALL abandon the access. A subsequent stale mem_resp SHALL have no effect.

Structure
REQ-036 The lsu_state_t enum and size/extension encodings SHALL live in package rv32i_types.
REQ-037 Lane shifting, byte-enable generation and extension SHALL be one combinational sub-module, lsu_align, parametrised by DATA_W.

Verification
REQ-038 Byte load: DATA_W=32, lb 0x103, mem_rdata 0x80000000 -> mem_address 0x100, rsp_rdata 0xFFFFFF80.
REQ-039 Half store: sh 0x102, wdata 0x0000BEEF -> byte_enable 4'b1100, mem_wdata 0xBEEF0000.
REQ-040 Split load: SPLIT_MISALIGNED=1, lw 0x0FE, beats 0x11223344 then 0x55667788 -> addresses 0x0FC then 0x100, rsp_rdata 0x77881122.
REQ-041 Misaligned fault: SPLIT_MISALIGNED=0, lw 0x0FE -> no mem_read, rsp_valid with rsp_misaligned=1 one cycle after acceptance.
REQ-042 Reset mid-access: rst low while in ACCESS1 with mem_read=1 -> mem_read=0 same cycle; mem_resp after release -> no rsp_valid.
REQ-043 Wide unsigned load: DATA_W=64, lwu 0x104, mem_rdata 0x80000001_00000000 -> rsp_rdata 0x00000000_80000001; ld with DATA_W=32 -> rsp_illegal=1.
